// File: rtl/haar_dwt2d_pipe.sv
// Purpose : one level of the 2-D Haar DWT on a row pair, producing LL/LH/HL/HH for N/2 blocks per beat.
// Latency : 2 clk edges from input acceptance to out_valid when out_ready is held high.
// Backpr. : valid/ready skid-free pipeline; in_ready falls only when both stages hold data and out_ready is low.
//
// Ports:
//   clk, rst_n            - single rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   - input handshake, one row pair per accepted beat
//   row0, row1            - even / odd row, N pixels of PIX_W bits, pixel 0 in the MSBs
//   mode                  - 0 = raw sums, 1 = floor(raw/4); sampled with the input beat
//   out_valid / out_ready - output handshake, one coefficient set per transferred beat
//   ll, lh, hl, hh        - N/2 signed COEF_W coefficients each, coefficient 0 in the MSBs
//   out_last              - beat is the final row pair of the frame
module haar_dwt2d_pipe #(
   parameter  int PIX_W  = 8,
   parameter  int N      = 8,
   parameter  int ROWS   = 8,
   localparam int COEF_W = PIX_W + 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N*PIX_W-1:0]        row0,
   input  logic [N*PIX_W-1:0]        row1,
   input  logic                      mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [(N/2)*COEF_W-1:0]   ll,
   output logic [(N/2)*COEF_W-1:0]   lh,
   output logic [(N/2)*COEF_W-1:0]   hl,
   output logic [(N/2)*COEF_W-1:0]   hh,
   output logic                      out_last
);

   localparam int NB    = N / 2;               // 2x2 blocks per row pair
   localparam int HW    = NB * COEF_W;         // width of one packed coefficient plane
   localparam int RP    = ROWS / 2;            // row pairs per frame
   localparam int CNT_W = (RP > 1) ? $clog2(RP) : 1;

   // ------------------------------------------------------------------
   // Handshake / stage-load control
   // ------------------------------------------------------------------
   logic s1_valid;
   logic s2_valid;
   logic s1_load;
   logic s2_load;
   logic in_acc;

   // A stage may load when it is empty or when its contents move on this
   // edge; the chain gives a combinational out_ready -> in_ready path.
   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;
   assign in_acc   = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Row-pair counter: frame position of the beat being accepted
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] pair_cnt;
   logic             cnt_last;

   // With ROWS == 2 the counter is pinned at 0 and every beat is last.
   assign cnt_last = (pair_cnt == CNT_W'(RP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_cnt <= '0;
      end else if (in_acc) begin
         pair_cnt <= cnt_last ? '0 : pair_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1 combinational: horizontal sum / difference per row
   // ------------------------------------------------------------------
   logic [HW-1:0] hs0_d;   // row0: a + b
   logic [HW-1:0] hd0_d;   // row0: a - b
   logic [HW-1:0] hs1_d;   // row1: c + d
   logic [HW-1:0] hd1_d;   // row1: c - d

   for (genvar k = 0; k < NB; k++) begin : g_horiz
      logic [COEF_W-1:0] px_a;
      logic [COEF_W-1:0] px_b;
      logic [COEF_W-1:0] px_c;
      logic [COEF_W-1:0] px_d;

      // Zero-extend to the coefficient width; two's-complement subtraction
      // at COEF_W then yields the correct signed difference.
      assign px_a = {3'b000, row0[(N-1-2*k)*PIX_W +: PIX_W]};
      assign px_b = {3'b000, row0[(N-2-2*k)*PIX_W +: PIX_W]};
      assign px_c = {3'b000, row1[(N-1-2*k)*PIX_W +: PIX_W]};
      assign px_d = {3'b000, row1[(N-2-2*k)*PIX_W +: PIX_W]};

      assign hs0_d[(NB-1-k)*COEF_W +: COEF_W] = px_a + px_b;
      assign hd0_d[(NB-1-k)*COEF_W +: COEF_W] = px_a - px_b;
      assign hs1_d[(NB-1-k)*COEF_W +: COEF_W] = px_c + px_d;
      assign hd1_d[(NB-1-k)*COEF_W +: COEF_W] = px_c - px_d;
   end

   // ------------------------------------------------------------------
   // Stage 1 registers
   // ------------------------------------------------------------------
   logic [HW-1:0] s1_hs0;
   logic [HW-1:0] s1_hd0;
   logic [HW-1:0] s1_hs1;
   logic [HW-1:0] s1_hd1;
   logic          s1_mode;
   logic          s1_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_last  <= 1'b0;
         s1_hs0   <= '0;
         s1_hd0   <= '0;
         s1_hs1   <= '0;
         s1_hd1   <= '0;
      end else if (s1_load) begin
         // Loading with nothing offered leaves a bubble: valid clears.
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mode <= mode;
            s1_last <= cnt_last;
            s1_hs0  <= hs0_d;
            s1_hd0  <= hd0_d;
            s1_hs1  <= hs1_d;
            s1_hd1  <= hd1_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 combinational: vertical combination and normalization
   // ------------------------------------------------------------------
   logic [HW-1:0] ll_d;
   logic [HW-1:0] lh_d;
   logic [HW-1:0] hl_d;
   logic [HW-1:0] hh_d;

   for (genvar k = 0; k < NB; k++) begin : g_vert
      logic signed [COEF_W-1:0] hs0;
      logic signed [COEF_W-1:0] hd0;
      logic signed [COEF_W-1:0] hs1;
      logic signed [COEF_W-1:0] hd1;
      logic signed [COEF_W-1:0] ll_raw;
      logic signed [COEF_W-1:0] lh_raw;
      logic signed [COEF_W-1:0] hl_raw;
      logic signed [COEF_W-1:0] hh_raw;

      assign hs0 = s1_hs0[(NB-1-k)*COEF_W +: COEF_W];
      assign hd0 = s1_hd0[(NB-1-k)*COEF_W +: COEF_W];
      assign hs1 = s1_hs1[(NB-1-k)*COEF_W +: COEF_W];
      assign hd1 = s1_hd1[(NB-1-k)*COEF_W +: COEF_W];

      // |LL| <= 4*(2^PIX_W - 1), which fits COEF_W signed with no overflow.
      assign ll_raw = hs0 + hs1;
      assign lh_raw = hs0 - hs1;
      assign hl_raw = hd0 + hd1;
      assign hh_raw = hd0 - hd1;

      // Arithmetic shift on a signed operand floors toward minus infinity.
      assign ll_d[(NB-1-k)*COEF_W +: COEF_W] = s1_mode ? (ll_raw >>> 2) : ll_raw;
      assign lh_d[(NB-1-k)*COEF_W +: COEF_W] = s1_mode ? (lh_raw >>> 2) : lh_raw;
      assign hl_d[(NB-1-k)*COEF_W +: COEF_W] = s1_mode ? (hl_raw >>> 2) : hl_raw;
      assign hh_d[(NB-1-k)*COEF_W +: COEF_W] = s1_mode ? (hh_raw >>> 2) : hh_raw;
   end

   // ------------------------------------------------------------------
   // Stage 2 registers (drive the outputs directly)
   // ------------------------------------------------------------------
   logic [HW-1:0] s2_ll;
   logic [HW-1:0] s2_lh;
   logic [HW-1:0] s2_hl;
   logic [HW-1:0] s2_hh;
   logic          s2_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_ll    <= '0;
         s2_lh    <= '0;
         s2_hl    <= '0;
         s2_hh    <= '0;
      end else if (s2_load) begin
         // s2_load is low during a stall, so the outputs hold their value.
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_last <= s1_last;
            s2_ll   <= ll_d;
            s2_lh   <= lh_d;
            s2_hl   <= hl_d;
            s2_hh   <= hh_d;
         end
      end
   end

   assign out_valid = s2_valid;
   // The last tag is only meaningful alongside a valid beat.
   assign out_last  = s2_valid && s2_last;
   assign ll        = s2_ll;
   assign lh        = s2_lh;
   assign hl        = s2_hl;
   assign hh        = s2_hh;

endmodule

// File: tb/tb_haar_dwt2d_pipe.sv
module tb_haar_dwt2d_pipe;

   localparam int PIX_W = 8;
   localparam int N     = 8;
   localparam int ROWS  = 8;
   localparam int CW    = PIX_W + 3;
   localparam int RW    = N * PIX_W;
   localparam int HW    = (N / 2) * CW;
   localparam int RP    = ROWS / 2;

   typedef struct {
      logic [HW-1:0] ll;
      logic [HW-1:0] lh;
      logic [HW-1:0] hl;
      logic [HW-1:0] hh;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [RW-1:0] row0 = '0;
   logic [RW-1:0] row1 = '0;
   logic          mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [HW-1:0] ll;
   logic [HW-1:0] lh;
   logic [HW-1:0] hl;
   logic [HW-1:0] hh;
   logic          out_last;

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   int   tb_cnt = 0;

   haar_dwt2d_pipe #(.PIX_W(PIX_W), .N(N), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .row0(row0), .row1(row1), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .ll(ll), .lh(lh), .hl(hl), .hh(hh),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: direct 2x2 Haar arithmetic on integers.
   function automatic exp_t model(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                                  input logic m, input logic lst);
      exp_t e;
      int a, b, c, d, vll, vlh, vhl, vhh;
      e.ll = '0; e.lh = '0; e.hl = '0; e.hh = '0;
      e.last = lst;
      for (int k = 0; k < N / 2; k++) begin
         a = int'(r0[(N-1-2*k)*PIX_W +: PIX_W]);
         b = int'(r0[(N-2-2*k)*PIX_W +: PIX_W]);
         c = int'(r1[(N-1-2*k)*PIX_W +: PIX_W]);
         d = int'(r1[(N-2-2*k)*PIX_W +: PIX_W]);
         vll = a + b + c + d;
         vhl = (a - b) + (c - d);
         vlh = (a + b) - (c + d);
         vhh = (a - b) - (c - d);
         if (m) begin
            vll = vll >>> 2;
            vhl = vhl >>> 2;
            vlh = vlh >>> 2;
            vhh = vhh >>> 2;
         end
         e.ll[(N/2-1-k)*CW +: CW] = vll[CW-1:0];
         e.lh[(N/2-1-k)*CW +: CW] = vlh[CW-1:0];
         e.hl[(N/2-1-k)*CW +: CW] = vhl[CW-1:0];
         e.hh[(N/2-1-k)*CW +: CW] = vhh[CW-1:0];
      end
      return e;
   endfunction

   function automatic int coef(input logic [HW-1:0] v, input int k);
      logic signed [CW-1:0] s;
      s = v[(N/2-1-k)*CW +: CW];
      return int'(s);
   endfunction

   task automatic rand_rows();
      for (int i = 0; i < N; i++) begin
         row0[i*PIX_W +: PIX_W] = PIX_W'($urandom);
         row1[i*PIX_W +: PIX_W] = PIX_W'($urandom);
      end
   endtask

   // Records an accepted beat in the scoreboard and advances the frame model.
   task automatic push_beat();
      sbq.push_back(model(row0, row1, mode, tb_cnt == RP - 1));
      tb_cnt = (tb_cnt + 1) % RP;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      sbq.delete();
      tb_cnt = 0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      checks++; if ((ll | lh | hl | hh) !== '0) begin failures++; $display("FAIL rst_coef: got ll=%h lh=%h hl=%h hh=%h want 0", ll, lh, hl, hh); end
      #2 rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
      tb_cnt = 0;
   endtask

   task automatic test_raw_mode();
      logic exp_last;
      exp_t e;
      @(posedge clk); #1;
      row0 = 64'h403E3D454749494A;
      row1 = 64'h3C373A3B3E404A4C;
      mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_accept: in_ready=%b want 1", in_ready); end
      exp_last = (tb_cnt == RP - 1);
      e = model(row0, row1, 1'b0, exp_last);
      tb_cnt = (tb_cnt + 1) % RP;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL raw_latency_early: out_valid=%b after 1 edge want 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL raw_latency: out_valid=%b after 2 edges want 1", out_valid); end
      checks++;
      if (coef(ll,0) !== 241 || coef(hl,0) !== 7 || coef(lh,0) !== 11 || coef(hh,0) !== -3) begin
         failures++;
         $display("FAIL raw_block0: got LL=%0d HL=%0d LH=%0d HH=%0d want 241 7 11 -3", coef(ll,0), coef(hl,0), coef(lh,0), coef(hh,0));
      end
      checks++;
      if (coef(ll,1) !== 247 || coef(hl,1) !== -9 || coef(lh,1) !== 13 || coef(hh,1) !== -7) begin
         failures++;
         $display("FAIL raw_block1: got LL=%0d HL=%0d LH=%0d HH=%0d want 247 -9 13 -7", coef(ll,1), coef(hl,1), coef(lh,1), coef(hh,1));
      end
      checks++;
      if (ll !== e.ll || lh !== e.lh || hl !== e.hl || hh !== e.hh || out_last !== e.last) begin
         failures++;
         $display("FAIL raw_all_blocks: got ll=%h lh=%h hl=%h hh=%h last=%b want ll=%h lh=%h hl=%h hh=%h last=%b",
                  ll, lh, hl, hh, out_last, e.ll, e.lh, e.hl, e.hh, e.last);
      end
      @(negedge clk);
   endtask

   task automatic test_norm_mode();
      @(posedge clk); #1;
      row0 = 64'h403E3D454749494A;
      row1 = 64'h3C373A3B3E404A4C;
      mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      tb_cnt = (tb_cnt + 1) % RP;
      @(posedge clk); #1 in_valid = 1'b0; mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL norm_valid: got %b want 1", out_valid); end
      checks++;
      if (coef(ll,0) !== 60 || coef(hl,0) !== 1 || coef(lh,0) !== 2 || coef(hh,0) !== -1) begin
         failures++;
         $display("FAIL norm_block0: got LL=%0d HL=%0d LH=%0d HH=%0d want 60 1 2 -1", coef(ll,0), coef(hl,0), coef(lh,0), coef(hh,0));
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int   sent = 0;
      int   recv = 0;
      int   cyc = 0;
      logic exp_rdy;
      logic stall_prev = 1'b0;
      logic [HW-1:0] p_ll, p_lh, p_hl, p_hh;
      logic p_last;
      logic [3:0] pat;
      exp_t e;
      pat = 4'b1001;
      p_ll = '0; p_lh = '0; p_hl = '0; p_hh = '0; p_last = 1'b0;
      while ((sent < 10 || sbq.size() != 0) && cyc < 200) begin
         @(posedge clk); #1;
         out_ready = pat[3 - (cyc % 4)];
         in_valid = (sent < 10);
         mode = 1'($urandom_range(0, 1));
         rand_rows();
         @(negedge clk);
         exp_rdy = !(sbq.size() == 2 && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy);
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || ll !== p_ll || lh !== p_lh || hl !== p_hl || hh !== p_hh || out_last !== p_last) begin
               failures++; $display("FAIL bp_stall_hold cyc %0d: got valid=%b ll=%h last=%b want valid=1 ll=%h last=%b",
                                    cyc, out_valid, ll, out_last, p_ll, p_last);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++; $display("FAIL bp_spurious cyc %0d: got an output beat want none", cyc);
            end else begin
               e = sbq.pop_front();
               if (ll !== e.ll || lh !== e.lh || hl !== e.hl || hh !== e.hh || out_last !== e.last) begin
                  failures++;
                  $display("FAIL bp_data beat %0d: got ll=%h lh=%h hl=%h hh=%h last=%b want ll=%h lh=%h hl=%h hh=%h last=%b",
                           recv, ll, lh, hl, hh, out_last, e.ll, e.lh, e.hl, e.hh, e.last);
               end
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            push_beat();
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         p_ll = ll; p_lh = lh; p_hl = hl; p_hh = hh; p_last = out_last;
         cyc++;
      end
      checks++;
      if (recv !== 10 || sbq.size() != 0) begin
         failures++; $display("FAIL bp_count: got %0d outputs (%0d pending) want 10 (0 pending)", recv, sbq.size());
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      int   sent = 0;
      int   cyc = 0;
      int   nb = 16;
      exp_t e;
      out_ready = 1'b1;
      while ((sent < nb || sbq.size() != 0) && cyc < 100) begin
         @(posedge clk); #1;
         in_valid = (sent < nb);
         mode = sent[0];
         rand_rows();
         @(negedge clk);
         if (in_valid) begin
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc %0d: got %b want 1", cyc, in_ready); end
         end
         if (cyc >= 2 && cyc <= nb + 1) begin
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_throughput cyc %0d: out_valid=%b want 1", cyc, out_valid); end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++; $display("FAIL b2b_spurious cyc %0d: got an output beat want none", cyc);
            end else begin
               e = sbq.pop_front();
               if (ll !== e.ll || lh !== e.lh || hl !== e.hl || hh !== e.hh || out_last !== e.last) begin
                  failures++;
                  $display("FAIL b2b_data cyc %0d: got ll=%h lh=%h hl=%h hh=%h last=%b want ll=%h lh=%h hl=%h hh=%h last=%b",
                           cyc, ll, lh, hl, hh, out_last, e.ll, e.lh, e.hl, e.hh, e.last);
               end
            end
         end
         if (in_valid && in_ready) begin
            push_beat();
            sent++;
         end
         cyc++;
      end
      checks++;
      if (sent !== nb || sbq.size() != 0) begin failures++; $display("FAIL b2b_count: sent %0d pending %0d want %0d and 0", sent, sbq.size(), nb); end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic test_frame_tag();
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      logic exp_last;
      do_reset();
      out_ready = 1'b1;
      while (recv < 9 && cyc < 60) begin
         @(posedge clk); #1;
         in_valid = (sent < 9);
         rand_rows();
         @(negedge clk);
         if (out_valid && out_ready) begin
            recv++;
            exp_last = (recv == 4 || recv == 8);
            checks++;
            if (out_last !== exp_last) begin
               failures++; $display("FAIL frame_last beat %0d: got %b want %b", recv, out_last, exp_last);
            end
         end
         if (in_valid && in_ready) begin
            sent++;
            tb_cnt = (tb_cnt + 1) % RP;
         end
         cyc++;
      end
      checks++;
      if (recv !== 9) begin failures++; $display("FAIL frame_count: got %0d outputs want 9", recv); end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      int   sent = 0;
      int   recv = 0;
      int   cyc = 0;
      exp_t e;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; rand_rows();
      @(posedge clk); #1 rand_rows();
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++; $display("FAIL mid_full: got out_valid=%b in_ready=%b want 1 and 0", out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || (ll | lh | hl | hh) !== '0) begin
         failures++; $display("FAIL mid_reset_clear: got valid=%b last=%b ll=%h lh=%h hl=%h hh=%h want all 0",
                              out_valid, out_last, ll, lh, hl, hh);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      sbq.delete();
      tb_cnt = 0;
      out_ready = 1'b1;
      while ((sent < 4 || sbq.size() != 0) && cyc < 40) begin
         @(posedge clk); #1;
         in_valid = (sent < 4);
         mode = 1'($urandom_range(0, 1));
         rand_rows();
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++; $display("FAIL mid_stale: got a beat from before reset want none");
            end else begin
               e = sbq.pop_front();
               if (ll !== e.ll || lh !== e.lh || hl !== e.hl || hh !== e.hh || out_last !== e.last) begin
                  failures++;
                  $display("FAIL mid_data beat %0d: got ll=%h last=%b want ll=%h last=%b", recv, ll, out_last, e.ll, e.last);
               end
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            push_beat();
            sent++;
         end
         cyc++;
      end
      checks++;
      if (recv !== 4) begin failures++; $display("FAIL mid_count: got %0d outputs want 4", recv); end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_raw_mode();
      test_norm_mode();
      test_backpressure();
      test_back_to_back();
      test_frame_tag();
      test_reset_midstream();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
